// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the integer ALU blocks.
// Contents:
//   DATA_WIDTH_DEF   default signed operand/result width
//   op_e             operation encoding (DIV = quotient, MOD = remainder)
//   div_state_e      divider FSM states
//   MAX_POS/MAX_NEG  saturation limits at the default width
// ----------------------------------------------------------------------------
package alu_pkg;

   localparam int DATA_WIDTH_DEF = 8;

   typedef enum logic {
      OP_DIV = 1'b0,
      OP_MOD = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX
   } div_state_e;

   localparam logic [DATA_WIDTH_DEF-1:0] MAX_POS = {1'b0, {(DATA_WIDTH_DEF-1){1'b1}}};
   localparam logic [DATA_WIDTH_DEF-1:0] MAX_NEG = {1'b1, {(DATA_WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/alu_div_step.sv
// ----------------------------------------------------------------------------
// alu_div_step
// One combinational restoring-division iteration on unsigned magnitudes.
// Ports:
//   shifted   in   MW  partial remainder already shifted left with the next
//                      dividend bit appended
//   divisor   in   MW  divisor magnitude
//   rem_next  out  MW  remainder after the conditional subtract
//   qbit      out  1   quotient bit (1 when the subtract succeeded)
// ----------------------------------------------------------------------------
module alu_div_step #(
   parameter int MW = 9
) (
   input  logic [MW-1:0] shifted,
   input  logic [MW-1:0] divisor,
   output logic [MW-1:0] rem_next,
   output logic          qbit
);

   // One extra bit so the borrow of the trial subtract is visible.
   logic [MW:0] diff;

   assign diff     = {1'b0, shifted} - {1'b0, divisor};
   assign qbit     = ~diff[MW];
   assign rem_next = qbit ? diff[MW-1:0] : shifted;

endmodule

// File: rtl/alu_int_divider.sv
// ----------------------------------------------------------------------------
// alu_int_divider
// Multi-cycle signed integer divider: IDLE -> CALC (DATA_WIDTH cycles) ->
// FIX (1 cycle) -> IDLE. Result, flags and done appear DATA_WIDTH+2 cycles
// after the cycle in which start is accepted.
// Build option: define ALU_DIV_MOD_EN to enable op=1 (remainder). Without it
// op is ignored and the quotient is always returned.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request, sampled only in IDLE
//   A, B         signed dividend / divisor
//   op           0 = DIV, 1 = MOD
//   Out          registered signed result
//   N, V, Z      registered negative / saturation-or-div-by-zero / zero flags
//   busy         high while an operation is in progress
//   done         one-cycle pulse when Out/N/V/Z are updated
// ----------------------------------------------------------------------------
module alu_int_divider
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic                  op,
   output logic [DATA_WIDTH-1:0] Out,
   output logic                  N,
   output logic                  V,
   output logic                  Z,
   output logic                  busy,
   output logic                  done
);

   localparam int MW = DATA_WIDTH + 1;
   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [DATA_WIDTH-1:0] MAX_P     = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] MAX_N     = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] MINUS_ONE = '1;
   localparam logic [CW-1:0]         LAST_CNT  = CW'(DATA_WIDTH - 1);

   div_state_e            state;
   logic [DATA_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] b_q;
   logic [DATA_WIDTH-1:0] dvd_q;   // dividend bits shift out, quotient bits shift in
   logic [DATA_WIDTH-1:0] rem_q;   // always < divisor <= 2^(DATA_WIDTH-1)
   logic [MW-1:0]         dsr_q;
   logic [CW-1:0]         cnt_q;
`ifdef ALU_DIV_MOD_EN
   op_e                   op_q;
`endif

   logic [MW-1:0]         a_mag;
   logic [MW-1:0]         b_mag;
   logic [MW-1:0]         shifted;
   logic [MW-1:0]         rem_next;
   logic                  qbit;
   logic [DATA_WIDTH-1:0] quo_s;
   logic [DATA_WIDTH-1:0] fix_out;
   logic                  fix_v;
   logic                  a_neg;
   logic                  b_neg;

   // Magnitudes are one bit wider so |MAX_N| is representable.
   assign a_mag = A[DATA_WIDTH-1] ? (MW'(0) - {1'b1, A}) : {1'b0, A};
   assign b_mag = B[DATA_WIDTH-1] ? (MW'(0) - {1'b1, B}) : {1'b0, B};

   // |A| <= 2^(DATA_WIDTH-1) fits in the low bits, and the remainder never
   // reaches bit DATA_WIDTH, so those top bits carry no information.
   logic unused_bits;
`ifdef ALU_DIV_MOD_EN
   assign unused_bits = ^{a_mag[DATA_WIDTH], rem_next[DATA_WIDTH]};
`else
   assign unused_bits = ^{a_mag[DATA_WIDTH], rem_next[DATA_WIDTH], op};
`endif

   assign shifted = {rem_q, dvd_q[DATA_WIDTH-1]};

   alu_div_step #(
      .MW (MW)
   ) u_step (
      .shifted  (shifted),
      .divisor  (dsr_q),
      .rem_next (rem_next),
      .qbit     (qbit)
   );

   // Sign fix-up and the special cases, evaluated in the FIX cycle.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
      a_neg   = a_q[DATA_WIDTH-1];
      b_neg   = b_q[DATA_WIDTH-1];
      quo_s   = (a_neg ^ b_neg) ? (DATA_WIDTH'(0) - dvd_q) : dvd_q;
      fix_out = quo_s;
      fix_v   = 1'b0;
      if (b_q == '0) begin
         fix_out = a_neg ? MAX_N : MAX_P;
         fix_v   = 1'b1;
      end else if (a_q == MAX_N && b_q == MINUS_ONE) begin
         fix_out = MAX_P;
         fix_v   = 1'b1;
      end
`ifdef ALU_DIV_MOD_EN
      if (op_q == OP_MOD) begin
         // Remainder takes the dividend sign; MAX_N mod -1 falls out as 0.
         fix_out = a_neg ? (DATA_WIDTH'(0) - rem_q) : rem_q;
         fix_v   = 1'b0;
         if (b_q == '0) begin
            fix_out = a_q;
            fix_v   = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         a_q   <= '0;
         b_q   <= '0;
         dvd_q <= '0;
         rem_q <= '0;
         dsr_q <= '0;
         cnt_q <= '0;
`ifdef ALU_DIV_MOD_EN
         op_q  <= OP_DIV;
`endif
         Out   <= '0;
         N     <= 1'b0;
         V     <= 1'b0;
         Z     <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q   <= A;
                  b_q   <= B;
                  dvd_q <= a_mag[DATA_WIDTH-1:0];
                  dsr_q <= b_mag;
                  rem_q <= '0;
                  cnt_q <= '0;
`ifdef ALU_DIV_MOD_EN
                  op_q  <= op_e'(op);
`endif
                  busy  <= 1'b1;
                  state <= ST_CALC;
               end
            end
            ST_CALC: begin
               rem_q <= rem_next[DATA_WIDTH-1:0];
               dvd_q <= {dvd_q[DATA_WIDTH-2:0], qbit};
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == LAST_CNT) state <= ST_FIX;
            end
            ST_FIX: begin
               Out   <= fix_out;
               N     <= fix_out[DATA_WIDTH-1];
               V     <= fix_v;
               Z     <= (fix_out == '0);
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_int_divider.sv
// ----------------------------------------------------------------------------
// tb_alu_int_divider
// Directed vectors for alu_int_divider (DATA_WIDTH = 8). The driver pushes the
// hand-computed response into a scoreboard queue; the monitor pops and
// compares whenever done is seen, including the cycle it arrived in.
// ----------------------------------------------------------------------------
module tb_alu_int_divider;

`ifdef ALU_DIV_MOD_EN
   localparam bit MOD_EN = 1'b1;
`else
   localparam bit MOD_EN = 1'b0;
`endif

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       op;
      logic [7:0] out;
      logic       n;
      logic       v;
      logic       z;
      string      name;
   } vec_t;

   typedef struct {
      logic [7:0] out;
      logic       n;
      logic       v;
      logic       z;
      int         cyc;
      string      name;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a_i;
   logic [7:0] b_i;
   logic       op_i;
   logic [7:0] out_o;
   logic       n_o;
   logic       v_o;
   logic       z_o;
   logic       busy_o;
   logic       done_o;

   int   n_vec  = 0;
   int   n_miss = 0;
   int   cyc    = 0;
   exp_t sb[$];

   alu_int_divider #(
      .DATA_WIDTH (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (a_i),
      .B     (b_i),
      .op    (op_i),
      .Out   (out_o),
      .N     (n_o),
      .V     (v_o),
      .Z     (z_o),
      .busy  (busy_o),
      .done  (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done_o) begin
         if (sb.size() == 0) begin
            check("spurious_done", 32'(done_o), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, " Out"}, 32'(out_o), 32'(e.out));
            check({e.name, " N"}, 32'(n_o), 32'(e.n));
            check({e.name, " V"}, 32'(v_o), 32'(e.v));
            check({e.name, " Z"}, 32'(z_o), 32'(e.z));
            check({e.name, " done_cycle"}, 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Drive one request; call at a point away from the rising edge.
   task automatic issue(input vec_t v, input bit push);
      exp_t e;
      a_i   = v.a;
      b_i   = v.b;
      op_i  = v.op;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (push) begin
         e.out  = v.out;
         e.n    = v.n;
         e.v    = v.v;
         e.z    = v.z;
         e.cyc  = cyc + 9;   // now in cycle 1; done lands in cycle 10
         e.name = v.name;
         sb.push_back(e);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #2;
         if (sb.size() == 0) break;
      end
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " Out"}, 32'(out_o), 32'd0);
      check({tag, " N"}, 32'(n_o), 32'd0);
      check({tag, " V"}, 32'(v_o), 32'd0);
      check({tag, " Z"}, 32'(z_o), 32'd1);
      check({tag, " busy"}, 32'(busy_o), 32'd0);
      check({tag, " done"}, 32'(done_o), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[13];
      vec_t v;

      tbl = '{
         '{8'd100, 8'd7,   1'b0, 8'h0E, 1'b0, 1'b0, 1'b0, "100 div 7"},
         '{8'h9C,  8'd7,   1'b0, 8'hF2, 1'b1, 1'b0, 1'b0, "-100 div 7"},
         '{8'h9C,  8'd7,   1'b1, MOD_EN ? 8'hFE : 8'hF2, 1'b1, 1'b0, 1'b0, "-100 mod 7"},
         '{8'h80,  8'hFF,  1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, "-128 div -1"},
         '{8'h80,  8'hFF,  1'b1, MOD_EN ? 8'h00 : 8'h7F, 1'b0, !MOD_EN, MOD_EN, "-128 mod -1"},
         '{8'd5,   8'd0,   1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, "5 div 0"},
         '{8'hFB,  8'd0,   1'b0, 8'h80, 1'b1, 1'b1, 1'b0, "-5 div 0"},
         '{8'd3,   8'd5,   1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "3 div 5"},
         '{8'd5,   8'd0,   1'b1, MOD_EN ? 8'h05 : 8'h7F, 1'b0, 1'b1, 1'b0, "5 mod 0"},
         '{8'h80,  8'd1,   1'b0, 8'h80, 1'b1, 1'b0, 1'b0, "-128 div 1"},
         '{8'd127, 8'hFF,  1'b0, 8'h81, 1'b1, 1'b0, 1'b0, "127 div -1"},
         '{8'd100, 8'hF9,  1'b1, MOD_EN ? 8'h02 : 8'hF2, !MOD_EN, 1'b0, 1'b0, "100 mod -7"},
         '{8'hF9,  8'd2,   1'b1, MOD_EN ? 8'hFF : 8'hFD, 1'b1, 1'b0, 1'b0, "-7 mod 2"}
      };

      rst_n = 1'b1;
      start = 1'b0;
      a_i   = '0;
      b_i   = '0;
      op_i  = 1'b0;
      #3 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");

      // Start accepted in the first cycle after reset release; busy window.
      @(negedge clk);
      rst_n = 1'b1;
      issue(tbl[0], 1'b1);
      check("busy cycle 1", 32'(busy_o), 32'd1);
      repeat (8) @(posedge clk);
      #1;
      check("busy cycle 9", 32'(busy_o), 32'd1);
      @(posedge clk);
      #1;
      check("busy cycle 10", 32'(busy_o), 32'd0);
      wait_idle();

      for (int i = 1; i < 13; i++) begin
         @(negedge clk);
         issue(tbl[i], 1'b1);
         wait_idle();
      end

      // Result held until the next done.
      repeat (5) @(negedge clk);
      check("Out held", 32'(out_o), 32'(tbl[12].out));

      // Second start in cycle 4 is ignored: exactly one done, with 50/5.
      @(negedge clk);
      v = '{8'd50, 8'd5, 1'b0, 8'h0A, 1'b0, 1'b0, 1'b0, "50 div 5"};
      issue(v, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      v = '{8'd1, 8'd1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, "ignored"};
      issue(v, 1'b0);
      wait_idle();
      repeat (12) @(negedge clk);

      // Back-to-back: second start in the done cycle, second done at cycle 20.
      @(negedge clk);
      v = '{8'd20, 8'd3, 1'b0, 8'h06, 1'b0, 1'b0, 1'b0, "20 div 3"};
      issue(v, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done_o) break;
      end
      v = '{8'hF9, 8'd2, 1'b0, 8'hFD, 1'b1, 1'b0, 1'b0, "-7 div 2 b2b"};
      issue(v, 1'b1);
      wait_idle();

      // Reset in cycle 5 of an operation: outputs clear, no done.
      @(negedge clk);
      v = '{8'd100, 8'd7, 1'b0, 8'h0E, 1'b0, 1'b0, 1'b0, "aborted"};
      issue(v, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid-op reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      v = '{8'd9, 8'hFE, 1'b0, 8'hFC, 1'b1, 1'b0, 1'b0, "9 div -2 after reset"};
      issue(v, 1'b1);
      wait_idle();
      repeat (12) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/alu_int_divider.md
ALU_INT_DIVIDER -- requirements
Module: alu_int_divider

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, signed operand/result width (range +-(2^(DATA_WIDTH-1))).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port A  input  DATA_WIDTH  signed dividend.
REQ-006 SHALL have port B  input  DATA_WIDTH  signed divisor.
REQ-007 SHALL have port op  input  1  0=DIV (quotient), 1=MOD (remainder).
REQ-008 SHALL have port Out  output  DATA_WIDTH  signed result, registered.
REQ-009 SHALL have ports N, V, Z  output  1 each  negative, saturation/divide-by-zero, zero; registered.
REQ-010 SHALL have port busy  output  1  high while operation in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse, result valid.

Function
REQ-012 SHALL implement FSM IDLE -> CALC (DATA_WIDTH cycles) -> FIX (1 cycle) -> IDLE.
REQ-013 SHALL, on start=1 in IDLE (cycle 0), latch A, B, op and enter CALC; busy high cycles 1..DATA_WIDTH+1.
REQ-014 SHALL assert done for exactly cycle DATA_WIDTH+2 (10 for width 8), with Out/N/V/Z updated in that cycle.
REQ-015 SHALL hold Out/N/V/Z stable until the next done.
REQ-016 SHALL ignore start while busy; start in the done cycle SHALL be accepted.
REQ-017 SHALL divide magnitudes by restoring shift-subtract, one quotient bit per CALC cycle, fixed latency for all operands.
REQ-018 SHALL truncate toward zero; quotient negative iff operand signs differ and quotient nonzero; remainder takes dividend sign.
REQ-019 SHALL handle B=0: DIV -> Out = max_pos if A>=0 else max_neg, V=1; MOD -> Out=A, V=1.
REQ-020 SHALL saturate max_neg / -1 to max_pos with V=1; max_neg MOD -1 SHALL give 0, V=0.
REQ-021 SHALL set V=0 for all other cases; N=Out[MSB]; Z=1 iff Out==0.
REQ-022 SHALL use internal magnitudes DATA_WIDTH+1 bits wide so |max_neg| is representable.

Reset
REQ-023 SHALL, on rst_n=0 (any time, incl. mid-CALC), go to IDLE with Out=0, N=0, V=0, Z=1, busy=0, done=0; in-flight operation discarded, no done.
REQ-024 SHALL accept start in the first cycle after rst_n deasserts.

Configuration
REQ-025 SHALL, with macro ALU_DIV_MOD_EN defined, support op=1 per REQ-018..020.
REQ-026 SHALL, with ALU_DIV_MOD_EN undefined, ignore op (port retained), always return quotient, and omit remainder sign-fix logic.

Structure
REQ-027 SHALL place in shared package alu_pkg: DATA_WIDTH default, op encoding enum (DIV/MOD), divider FSM state enum, max_pos/max_neg constants.
REQ-028 SHALL instantiate one combinational sub-module alu_div_step (one restoring iteration: shifted remainder, divisor -> next remainder, quotient bit).

Verification
REQ-029 SHALL cover: A=100, B=7, op=DIV -> done at cycle 10, Out=14, N=0, V=0, Z=0.
REQ-030 SHALL cover (macro on): A=-100, B=7, op=MOD -> Out=-2 (0xFE), N=1, V=0; op=DIV -> Out=-14.
REQ-031 SHALL cover: A=-128, B=-1, DIV -> Out=127, V=1; MOD -> Out=0, Z=1, V=0.
REQ-032 SHALL cover: A=5,B=0 DIV -> 127,V=1; A=-5,B=0 DIV -> -128,V=1,N=1; A=3,B=5 DIV -> 0,Z=1.
REQ-033 SHALL cover: second start pulsed in cycle 4 of an operation -> ignored, exactly one done; back-to-back start in done cycle -> second done at cycle 20.
REQ-034 SHALL cover: rst_n low in cycle 5 of an operation -> outputs at reset values, no done; new operation after release completes correctly.
